ym3438_ch_mix: RTL and testbench
================================

# ym3438_ch_mix

Stereo channel mixer directly downstream of the per-channel output stage. It consumes the time-multiplexed 9-bit offset-binary channel samples (`ch_out`), applies each channel's left/right pan enables and sums all six channels per output frame into signed left and right words. It delivers one stereo sample per frame with a single-cycle valid strobe to the output/DAC interface. A sequence checker flags out-of-order or truncated frames.

## Interface
- `NUM_CH`, default 6: channels per frame; indices 0..NUM_CH-1.
- `OUT_W`, default 12: output width. Must be ≥ 9+ceil(log2(NUM_CH)), which is 12 for 6 channels.
- `MCLK` in 1: single clock; all state changes on rising edge.
- `IC` in 1: reset, asynchronous, active-low.
- `ch_out` in 9: channel sample, offset binary (0x100 = zero).
- `ch_valid` in 1: `ch_out`/`ch_idx`/`pan` are valid this cycle.
- `ch_idx` in 3: channel number of the current sample.
- `pan` in 2: `pan[1]` = left enable, `pan[0]` = right enable (register B4 bits 7:6 of that channel).
- `frame_sync` in 1: single-cycle pulse marking frame start.
- `err_clr` in 1: clears `err`.
- `out_l`, `out_r` out OUT_W: signed two's-complement frame sums, held between frames.
- `out_valid` out 1: one-cycle pulse when `out_l`/`out_r` update.
- `err` out 1: sticky sequence-error flag.

## Operation
- Sample conversion: signed s = {~ch_out[8], ch_out[7:0]}, giving a range of −256..+255. Sign-extend to OUT_W.
- Contribution per channel: left += s if `pan[1]`, else 0; right += s if `pan[0]`, else 0.
- No saturation is needed: 6×[−256,255] = [−1536,1530] fits in 12 bits.
- States:
  - IDLE: wait for `frame_sync`.
  - ACCUM: `exp_idx` counter runs 0..NUM_CH-1; accumulators `acc_l`/`acc_r` are active.
- Transitions and events:
  - IDLE + `frame_sync` → ACCUM. Clear `acc_l`/`acc_r`; `exp_idx` = 0.
  - ACCUM + `ch_valid` with `ch_idx` == `exp_idx` < NUM_CH-1 → accumulate; `exp_idx`++.
  - ACCUM + `ch_valid` with `ch_idx` == NUM_CH-1 == `exp_idx` → `out_l` = `acc_l` + contribution and `out_r` likewise. Pulse `out_valid`; go to IDLE.
  - ACCUM + `ch_valid` with `ch_idx` ≠ `exp_idx` → set `err`, discard the frame, go to IDLE. Outputs are unchanged.
  - ACCUM + `frame_sync` before channel NUM_CH-1 (truncated frame) → set `err`, clear accumulators, restart at `exp_idx` = 0 and stay in ACCUM.
  - IDLE + `ch_valid` → ignored; no error.
- Simultaneous events:
  - `frame_sync` and `ch_valid` in the same cycle: the frame restart happens first. A sample with `ch_idx` = 0 is then accumulated as the first channel (`exp_idx` → 1); any other index sets `err` and returns to IDLE.
  - `err_clr` and a new error in the same cycle: `err` stays 1 (set wins).
- Reset (`IC` low, asynchronous, any time including mid-frame):
  - State IDLE, `exp_idx` 0, accumulators 0.
  - `out_l` = `out_r` = 0, `out_valid` = 0, `err` = 0.

## Timing
- All outputs are registered.
- `out_valid` is high for exactly the cycle after the edge that samples the last channel. Latency is 1 MCLK from the final `ch_valid`.
- `out_l`/`out_r` change only together with `out_valid`.
- The minimum frame is `frame_sync` plus NUM_CH consecutive `ch_valid` cycles. Gaps between `ch_valid` cycles are allowed without limit.
- Back-to-back frames: `frame_sync` may coincide with the cycle in which `out_valid` is high.

## Structure
- Shared package `ym3438_pkg`:
  - constants `YM_NUM_CH` (6), `YM_CH_W` (9), `YM_CH_ZERO` (9'h100);
  - function `ym_ch_to_signed`;
  - enum type for the mixer states.
- One sub-module, `ym3438_ch_mix_acc`: a single-side pan-gated signed accumulator with clear/load/add. It is instantiated twice, for L and R. The FSM, index counter and error logic stay in the top.

## Test plan
- Reset, then 6 channels of `ch_out` = 0x1FF with `pan` = 2'b11 → one `out_valid`; `out_l` = `out_r` = 0x5FA (+1530). Repeat with 0x000 → 0xA00 (−1536).
- Mixed pan: ch0 = 0x1FF `pan` = 10, ch1 = 0x000 `pan` = 01, ch2..5 = 0x100 → `out_l` = +255, `out_r` = −256.
- Order error: send idx 0, 1, 3 → `err` = 1 with no `out_valid`; next full frame still outputs correctly. `err` stays 1 until `err_clr`.
- Truncated frame: `frame_sync` after idx 2 → `err` = 1. The restarted frame's sum excludes the earlier partial data.
- Same-cycle `frame_sync` + `ch_valid` idx 0 (0x180, `pan` 11), idx 1..5 = 0x100 → `out_l` = `out_r` = +128.
- Assert `IC` low mid-frame with `out_l` nonzero → all outputs 0 immediately; the first full frame after release is correct.

Source files
------------

// File: rtl/ym3438_ch_mix_pkg.sv
// ---------------------------------------------------------------------------
// ym3438_pkg
//   Shared definitions for the YM3438 channel mixer slice.
//   - YM_NUM_CH   : channels per output frame
//   - YM_CH_W     : width of one channel sample from the output stage
//   - YM_CH_ZERO  : offset-binary code for a zero-valued sample
//   - mix_state_t : mixer FSM states
//   - ym_ch_to_signed() : offset-binary sample -> two's-complement sample
// ---------------------------------------------------------------------------
package ym3438_pkg;

    localparam int             YM_NUM_CH  = 6;
    localparam int             YM_CH_W    = 9;
    localparam logic [YM_CH_W-1:0] YM_CH_ZERO = 9'h100;

    typedef enum logic {
        MIX_IDLE  = 1'b0,
        MIX_ACCUM = 1'b1
    } mix_state_t;

    // Offset binary to two's complement is a flip of the MSB: 0x100 -> 0,
    // 0x1FF -> +255, 0x000 -> -256.
    function automatic logic signed [YM_CH_W-1:0] ym_ch_to_signed(
        input logic [YM_CH_W-1:0] ch
    );
        return {~ch[YM_CH_W-1], ch[YM_CH_W-2:0]};
    endfunction

endpackage : ym3438_pkg

// File: rtl/ym3438_ch_mix_if.sv
// ---------------------------------------------------------------------------
// ym3438_ch_mix_if
//   Channel-sample bus into the mixer and stereo frame bus out of it.
//   Input side  : ch_out, ch_valid, ch_idx, pan, frame_sync
//   Output side : out_l, out_r, out_valid
//   modport master : upstream source / output consumer
//   modport slave  : the mixer itself
// ---------------------------------------------------------------------------
interface ym3438_ch_mix_if
    import ym3438_pkg::*;
#(
    parameter int OUT_W = 12
) ();

    logic [YM_CH_W-1:0]      ch_out;      // offset-binary sample
    logic                    ch_valid;    // ch_out/ch_idx/pan valid
    logic [2:0]              ch_idx;      // channel number of ch_out
    logic [1:0]              pan;         // [1] = left enable, [0] = right enable
    logic                    frame_sync;  // one-cycle frame start pulse
    logic signed [OUT_W-1:0] out_l;       // left frame sum
    logic signed [OUT_W-1:0] out_r;       // right frame sum
    logic                    out_valid;   // one-cycle pulse on frame update

    modport master (
        output ch_out, ch_valid, ch_idx, pan, frame_sync,
        input  out_l, out_r, out_valid
    );

    modport slave (
        input  ch_out, ch_valid, ch_idx, pan, frame_sync,
        output out_l, out_r, out_valid
    );

endinterface : ym3438_ch_mix_if

// File: rtl/ym3438_ch_mix_acc.sv
// ---------------------------------------------------------------------------
// ym3438_ch_mix_acc
//   One side (left or right) of the stereo mixer: a pan-gated signed
//   accumulator plus the registered frame output.
//   Ports:
//     MCLK, IC  : clock, asynchronous active-low reset
//     clr       : start a new frame (accumulator base becomes 0)
//     add       : a sample is accepted this cycle
//     load      : accepted sample is the last one; publish the frame sum
//     en        : pan enable for this side
//     smp       : signed sample
//     sum_out   : registered frame sum, held between frames
// ---------------------------------------------------------------------------
module ym3438_ch_mix_acc
    import ym3438_pkg::*;
#(
    parameter int OUT_W = 12
) (
    input  logic                      MCLK,
    input  logic                      IC,
    input  logic                      clr,
    input  logic                      add,
    input  logic                      load,
    input  logic                      en,
    input  logic signed [YM_CH_W-1:0] smp,
    output logic signed [OUT_W-1:0]   sum_out
);

    logic signed [OUT_W-1:0] acc;
    logic signed [OUT_W-1:0] base;
    logic signed [OUT_W-1:0] contrib;
    logic signed [OUT_W-1:0] acc_next;

    // clr and add may coincide (frame restart together with channel 0), so
    // the restart is applied to the base before the new sample is added.
    // NOTE: every signal driven here gets a value on every path, otherwise
    // the tool infers a latch to hold the old value.
    always_comb begin
        base     = clr ? '0 : acc;
        contrib  = (add && en) ? {{(OUT_W-YM_CH_W){smp[YM_CH_W-1]}}, smp} : '0;
        acc_next = base + contrib;
    end

    // NOTE: non-blocking assignments keep every flop sampling the values
    // from before the edge, independent of statement order.
    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            acc     <= '0;
            sum_out <= '0;
        end else begin
            if (clr || add) begin
                acc <= acc_next;
            end
            if (load) begin
                sum_out <= acc_next;
            end
        end
    end

endmodule : ym3438_ch_mix_acc

// File: rtl/ym3438_ch_mix.sv
// ---------------------------------------------------------------------------
// ym3438_ch_mix
//   Stereo channel mixer. Consumes time-multiplexed offset-binary channel
//   samples, gates them by per-channel pan enables and sums NUM_CH channels
//   per frame into signed left/right words with a one-cycle valid strobe.
//   Out-of-order or truncated frames raise a sticky error flag.
//   Ports:
//     MCLK    : clock
//     IC      : asynchronous active-low reset
//     bus     : channel input / stereo output bus (slave side)
//     err_clr : clears err (a new error in the same cycle wins)
//     err     : sticky sequence-error flag
//   OUT_W must be at least 9 + ceil(log2(NUM_CH)) so the sum cannot wrap.
// ---------------------------------------------------------------------------
module ym3438_ch_mix
    import ym3438_pkg::*;
#(
    parameter int NUM_CH = YM_NUM_CH,
    parameter int OUT_W  = 12
) (
    input  logic                  MCLK,
    input  logic                  IC,
    ym3438_ch_mix_if.slave        bus,
    input  logic                  err_clr,
    output logic                  err
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_CH - 1);

    mix_state_t                state;
    mix_state_t                state_next;
    logic [2:0]                exp_idx;
    logic [2:0]                exp_next;
    logic [2:0]                cur_idx;
    logic                      active;
    logic                      acc_clr;
    logic                      acc_add;
    logic                      acc_load;
    logic                      err_set;
    logic signed [YM_CH_W-1:0] ch_s;

    assign ch_s = ym_ch_to_signed(bus.ch_out);

    // A frame_sync is handled before any sample in the same cycle: it
    // restarts the frame, so the sample is judged against index 0.
    always_comb begin
        state_next = state;
        exp_next   = exp_idx;
        acc_clr    = 1'b0;
        acc_add    = 1'b0;
        acc_load   = 1'b0;
        err_set    = 1'b0;
        active     = (state == MIX_ACCUM) || bus.frame_sync;
        cur_idx    = bus.frame_sync ? 3'd0 : exp_idx;

        if (bus.frame_sync) begin
            acc_clr    = 1'b1;
            state_next = MIX_ACCUM;
            exp_next   = 3'd0;
            // Any frame_sync while still accumulating means the previous
            // frame never reached its last channel.
            if (state == MIX_ACCUM) begin
                err_set = 1'b1;
            end
        end

        if (active && bus.ch_valid) begin
            if (bus.ch_idx == cur_idx) begin
                acc_add = 1'b1;
                if (cur_idx == LAST_IDX) begin
                    acc_load   = 1'b1;
                    state_next = MIX_IDLE;
                    exp_next   = 3'd0;
                end else begin
                    exp_next = cur_idx + 3'd1;
                end
            end else begin
                // Out-of-order sample: drop the frame, outputs untouched.
                err_set    = 1'b1;
                state_next = MIX_IDLE;
                exp_next   = 3'd0;
            end
        end
    end

    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            state         <= MIX_IDLE;
            exp_idx       <= 3'd0;
            bus.out_valid <= 1'b0;
            err           <= 1'b0;
        end else begin
            state         <= state_next;
            exp_idx       <= exp_next;
            bus.out_valid <= acc_load;
            err           <= err_set | (err & ~err_clr);
        end
    end

    ym3438_ch_mix_acc #(
        .OUT_W (OUT_W)
    ) u_acc_l (
        .MCLK    (MCLK),
        .IC      (IC),
        .clr     (acc_clr),
        .add     (acc_add),
        .load    (acc_load),
        .en      (bus.pan[1]),
        .smp     (ch_s),
        .sum_out (bus.out_l)
    );

    ym3438_ch_mix_acc #(
        .OUT_W (OUT_W)
    ) u_acc_r (
        .MCLK    (MCLK),
        .IC      (IC),
        .clr     (acc_clr),
        .add     (acc_add),
        .load    (acc_load),
        .en      (bus.pan[0]),
        .smp     (ch_s),
        .sum_out (bus.out_r)
    );

endmodule : ym3438_ch_mix

// File: tb/tb_ym3438_ch_mix.sv
// ---------------------------------------------------------------------------
// tb_ym3438_ch_mix
//   Self-checking bench for ym3438_ch_mix. Expected frame sums are queued
//   when a frame is issued; a monitor pops and compares on every out_valid.
// ---------------------------------------------------------------------------
module tb_ym3438_ch_mix;
    import ym3438_pkg::*;

    logic MCLK = 1'b0;
    logic IC;
    logic err_clr;
    logic err;

    ym3438_ch_mix_if #(.OUT_W(12)) bus ();

    ym3438_ch_mix #(
        .NUM_CH (6),
        .OUT_W  (12)
    ) dut (
        .MCLK    (MCLK),
        .IC      (IC),
        .bus     (bus),
        .err_clr (err_clr),
        .err     (err)
    );

    always #5 MCLK = ~MCLK;

    int errors = 0;
    int checks = 0;
    int n_push = 0;
    int n_out  = 0;
    int exp_l_q[$];
    int exp_r_q[$];
    int mon_l;
    int mon_r;

    logic [8:0] fr_smp[6];
    logic [1:0] fr_pan[6];
    logic [2:0] fr_idx[6];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Scoreboard monitor: outputs are sampled on the falling edge.
    always @(negedge MCLK) begin
        if (bus.out_valid === 1'b1) begin
            n_out++;
            if (exp_l_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                mon_l = exp_l_q.pop_front();
                mon_r = exp_r_q.pop_front();
                check("out_l", int'(bus.out_l), mon_l);
                check("out_r", int'(bus.out_r), mon_r);
            end
        end
    end

    task automatic push_exp(input int l, input int r);
        exp_l_q.push_back(l);
        exp_r_q.push_back(r);
        n_push++;
    endtask

    // Reference: offset-binary value minus 256, summed per enabled side.
    task automatic push_model();
        int l = 0;
        int r = 0;
        for (int i = 0; i < 6; i++) begin
            int s = int'(fr_smp[i]) - 256;
            if (fr_pan[i][1]) l += s;
            if (fr_pan[i][0]) r += s;
        end
        push_exp(l, r);
    endtask

    task automatic drive(input bit sync, input bit valid, input logic [2:0] idx,
                         input logic [8:0] smp, input logic [1:0] pn, input bit clr);
        bus.frame_sync = sync;
        bus.ch_valid   = valid;
        bus.ch_idx     = idx;
        bus.ch_out     = smp;
        bus.pan        = pn;
        err_clr        = clr;
        @(negedge MCLK);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 3'($urandom), 9'($urandom), 2'($urandom), 1'b0);
    endtask

    task automatic set_uniform(input logic [8:0] smp, input logic [1:0] pn);
        for (int i = 0; i < 6; i++) begin
            fr_smp[i] = smp;
            fr_pan[i] = pn;
            fr_idx[i] = 3'(i);
        end
    endtask

    task automatic set_random();
        for (int i = 0; i < 6; i++) begin
            fr_smp[i] = 9'($urandom);
            fr_pan[i] = 2'($urandom);
            fr_idx[i] = 3'(i);
        end
    endtask

    // Sends frame_sync (alone, or together with the first sample) and then
    // n_ch samples with random idle gaps of up to max_gap cycles.
    task automatic send_frame(input bit sync_first, input int n_ch, input int max_gap);
        if (!sync_first) drive(1'b1, 1'b0, 3'd0, 9'h100, 2'b00, 1'b0);
        for (int i = 0; i < n_ch; i++) begin
            if (!(sync_first && i == 0)) idle($urandom_range(max_gap, 0));
            drive(sync_first && i == 0, 1'b1, fr_idx[i], fr_smp[i], fr_pan[i], 1'b0);
        end
    endtask

    initial begin
        IC = 1'b0;
        bus.frame_sync = 1'b0;
        bus.ch_valid   = 1'b0;
        bus.ch_idx     = 3'd0;
        bus.ch_out     = YM_CH_ZERO;
        bus.pan        = 2'b00;
        err_clr        = 1'b0;
        repeat (3) @(negedge MCLK);
        check("reset_out_l", int'(bus.out_l), 0);
        check("reset_out_r", int'(bus.out_r), 0);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_err", int'(err), 0);
        IC = 1'b1;
        idle(2);

        // Full-scale positive and negative frames.
        set_uniform(9'h1FF, 2'b11);
        push_exp(1530, 1530);
        send_frame(1'b0, 6, 0);
        idle(2);
        set_uniform(9'h000, 2'b11);
        push_exp(-1536, -1536);
        send_frame(1'b0, 6, 1);
        idle(2);

        // Mixed pan.
        set_uniform(9'h100, 2'b11);
        fr_smp[0] = 9'h1FF; fr_pan[0] = 2'b10;
        fr_smp[1] = 9'h000; fr_pan[1] = 2'b01;
        push_exp(255, -256);
        send_frame(1'b0, 6, 3);
        idle(3);
        check("out_l_hold", int'(bus.out_l), 255);

        // Order error: 0, 1, 3.
        set_uniform(9'h1FF, 2'b11);
        fr_idx[2] = 3'd3;
        send_frame(1'b0, 3, 1);
        check("order_err", int'(err), 1);
        check("order_out_l_kept", int'(bus.out_l), 255);
        idle(2);
        set_random();
        push_model();
        send_frame(1'b0, 6, 2);
        idle(2);
        check("err_sticky", int'(err), 1);

        // err_clr in the same cycle as a new error: set wins.
        drive(1'b1, 1'b0, 3'd0, 9'h100, 2'b11, 1'b0);
        drive(1'b0, 1'b1, 3'd0, 9'h150, 2'b11, 1'b0);
        drive(1'b0, 1'b1, 3'd2, 9'h150, 2'b11, 1'b1);
        check("err_set_wins", int'(err), 1);
        drive(1'b0, 1'b0, 3'd0, 9'h100, 2'b00, 1'b1);
        check("err_cleared", int'(err), 0);

        // Samples while idle are ignored.
        drive(1'b0, 1'b1, 3'd3, 9'h1AB, 2'b11, 1'b0);
        drive(1'b0, 1'b1, 3'd0, 9'h1AB, 2'b11, 1'b0);
        idle(2);
        check("idle_ignore_err", int'(err), 0);

        // Truncated frame: restart discards the partial sums.
        set_uniform(9'h1FF, 2'b11);
        send_frame(1'b0, 3, 1);
        set_random();
        push_model();
        send_frame(1'b0, 6, 2);
        idle(1);
        check("trunc_err", int'(err), 1);
        drive(1'b0, 1'b0, 3'd0, 9'h100, 2'b00, 1'b1);
        check("trunc_err_clr", int'(err), 0);

        // frame_sync together with channel 0.
        set_uniform(9'h100, 2'b11);
        fr_smp[0] = 9'h180;
        for (int i = 1; i < 6; i++) fr_pan[i] = 2'($urandom);
        push_exp(128, 128);
        send_frame(1'b1, 6, 1);
        idle(1);

        // Random frames, some back-to-back with out_valid.
        for (int f = 0; f < 16; f++) begin
            set_random();
            push_model();
            send_frame(1'($urandom), 6, (f % 3 == 0) ? 0 : 3);
        end
        idle(2);
        check("random_no_err", int'(err), 0);

        // Asynchronous reset mid-frame.
        set_uniform(9'h1FF, 2'b11);
        push_exp(1530, 1530);
        send_frame(1'b0, 6, 0);
        idle(1);
        drive(1'b1, 1'b0, 3'd0, 9'h100, 2'b00, 1'b0);
        drive(1'b0, 1'b1, 3'd1, 9'h100, 2'b00, 1'b0);
        drive(1'b1, 1'b0, 3'd0, 9'h100, 2'b00, 1'b0);
        drive(1'b0, 1'b1, 3'd0, 9'h1FF, 2'b11, 1'b0);
        drive(1'b0, 1'b1, 3'd1, 9'h1FF, 2'b11, 1'b0);
        bus.ch_valid = 1'b0;
        check("pre_reset_out_l", int'(bus.out_l), 1530);
        check("pre_reset_err", int'(err), 1);
        #2 IC = 1'b0;
        #1;
        check("async_rst_out_l", int'(bus.out_l), 0);
        check("async_rst_out_r", int'(bus.out_r), 0);
        check("async_rst_out_valid", int'(bus.out_valid), 0);
        check("async_rst_err", int'(err), 0);
        @(negedge MCLK);
        IC = 1'b1;
        idle(1);
        set_random();
        push_model();
        send_frame(1'b0, 6, 1);

        idle(4);
        check("scoreboard_empty", exp_l_q.size(), 0);
        check("out_valid_count", n_out, n_push);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ym3438_ch_mix
